// File: rtl/complex_accum_n_if.sv
// Streaming handshake bundle for complex_accum_n: upstream samples, flush, and the
// registered complex result with its overflow flag.
//
// Handshake semantics: a transfer happens on a rising clk edge where both valid and
// ready are 1 on that channel. The producer holds its data stable while valid is 1
// and ready is 0. Ready may depend combinationally on the consumer's state, but valid
// never depends on ready.
interface complex_accum_n_if #(
  parameter int W  = 7,
  parameter int OW = 8
);
  logic                 flush;
  logic                 in_valid;
  logic                 in_ready;
  logic signed [W-1:0]  in_Re;
  logic signed [W-1:0]  in_Im;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [OW-1:0] out_Re;
  logic signed [OW-1:0] out_Im;
  logic                 out_ovf;

  modport master (
    output flush, in_valid, in_Re, in_Im, out_ready,
    input  in_ready, out_valid, out_Re, out_Im, out_ovf
  );

  modport slave (
    input  flush, in_valid, in_Re, in_Im, out_ready,
    output in_ready, out_valid, out_Re, out_Im, out_ovf
  );
endinterface

// File: rtl/complex_accum_n.sv
// Streaming complex accumulator: sums N_TERMS complex samples per frame in guard-bit
// accumulators, then narrows the exact sum once into the output format.
module complex_accum_n #(
  parameter int QI      = 3,
  parameter int QF      = 3,
  parameter int N_TERMS = 9,
  parameter int OUT_QI  = QI + 1,
  parameter int SAT_EN  = 1
) (
  input  logic             clk,
  input  logic             rst,
  complex_accum_n_if.slave bus,
  output logic             state_dbg
);
  localparam int W  = QI + QF + 1;
  localparam int OW = OUT_QI + QF + 1;
  localparam int CW = $clog2(N_TERMS);
  localparam int AW = W + CW;
  localparam int XW = ((AW > OW) ? AW : OW) + 1;
  localparam logic [CW-1:0]        LAST  = CW'(N_TERMS - 1);
  localparam logic signed [XW-1:0] MAX_V = {{(XW-OW+1){1'b0}}, {(OW-1){1'b1}}};
  localparam logic signed [XW-1:0] MIN_V = ~MAX_V;

  typedef enum logic {
    IDLE  = 1'b0,
    ACCUM = 1'b1
  } state_t;

  state_t                state_q, state_d;
  logic [CW-1:0]         cnt_q, cnt_d;
  logic signed [AW-1:0]  acc_re_q, acc_re_d;
  logic signed [AW-1:0]  acc_im_q, acc_im_d;
  logic signed [OW-1:0]  out_re_q, out_re_d;
  logic signed [OW-1:0]  out_im_q, out_im_d;
  logic                  out_valid_q, out_valid_d;
  logic                  out_ovf_q, out_ovf_d;

  logic                  in_ready;
  logic                  accept;
  logic signed [AW-1:0]  sum_re, sum_im;
  logic [OW:0]           nar_re, nar_im;

  function automatic logic signed [AW-1:0] widen(input logic signed [W-1:0] x);
    return {{CW{x[W-1]}}, x};
  endfunction

  // Returns {ovf, value}; the comparison is done one bit wider than either format
  // so the bounds themselves are always representable.
  function automatic logic [OW:0] narrow(input logic signed [AW-1:0] v);
    logic signed [XW-1:0] x;
    logic [OW-1:0]        r;
    logic                 ovf;
    x   = {{(XW-AW){v[AW-1]}}, v};
    ovf = (x > MAX_V) || (x < MIN_V);
    if (ovf && (SAT_EN != 0)) begin
      r = x[XW-1] ? MIN_V[OW-1:0] : MAX_V[OW-1:0];
    end else begin
      r = x[OW-1:0];
    end
    return {ovf, r};
  endfunction

  assign in_ready = !out_valid_q || bus.out_ready;
  assign accept   = bus.in_valid && in_ready && !bus.flush;
  assign sum_re   = acc_re_q + widen(bus.in_Re);
  assign sum_im   = acc_im_q + widen(bus.in_Im);
  assign nar_re   = narrow(sum_re);
  assign nar_im   = narrow(sum_im);

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    acc_re_d    = acc_re_q;
    acc_im_d    = acc_im_q;
    out_re_d    = out_re_q;
    out_im_d    = out_im_q;
    out_ovf_d   = out_ovf_q;
    out_valid_d = out_valid_q;

    if (out_valid_q && bus.out_ready) begin
      out_valid_d = 1'b0;
    end

    // Flush only touches the partial frame; a pending result stays presented.
    if (bus.flush) begin
      state_d  = IDLE;
      cnt_d    = '0;
      acc_re_d = '0;
      acc_im_d = '0;
    end else if (accept) begin
      if (cnt_q == LAST) begin
        out_re_d    = nar_re[OW-1:0];
        out_im_d    = nar_im[OW-1:0];
        out_ovf_d   = nar_re[OW] || nar_im[OW];
        out_valid_d = 1'b1;
        state_d     = IDLE;
        cnt_d       = '0;
        acc_re_d    = '0;
        acc_im_d    = '0;
      end else begin
        state_d  = ACCUM;
        cnt_d    = cnt_q + CW'(1);
        acc_re_d = sum_re;
        acc_im_d = sum_im;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      acc_re_q    <= '0;
      acc_im_q    <= '0;
      out_re_q    <= '0;
      out_im_q    <= '0;
      out_ovf_q   <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      acc_re_q    <= acc_re_d;
      acc_im_q    <= acc_im_d;
      out_re_q    <= out_re_d;
      out_im_q    <= out_im_d;
      out_ovf_q   <= out_ovf_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = out_valid_q;
  assign bus.out_Re    = out_re_q;
  assign bus.out_Im    = out_im_q;
  assign bus.out_ovf   = out_ovf_q;
  assign state_dbg     = (state_q == ACCUM);
endmodule

// File: tb/tb_complex_accum_n.sv
// Bench for complex_accum_n: saturating and wrapping instances share one stimulus
// stream; a frame-level reference model feeds expected queues checked by a monitor.
module tb_complex_accum_n;
  localparam int QI      = 3;
  localparam int QF      = 3;
  localparam int N_TERMS = 9;
  localparam int W       = QI + QF + 1;
  localparam int OW      = QI + 1 + QF + 1;
  localparam int LIM     = 1 << (OW - 1);
  localparam logic signed [W-1:0] MAXI = {1'b0, {(W-1){1'b1}}};
  localparam logic signed [W-1:0] MINI = ~MAXI;

  // ---------------- clock / reset / drive signals ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic in_valid = 1'b0;
  logic flush = 1'b0;
  logic out_ready = 1'b1;
  logic signed [W-1:0] in_re = '0;
  logic signed [W-1:0] in_im = '0;
  logic state_s, state_w;

  always #5 clk = ~clk;

  complex_accum_n_if #(.W(W), .OW(OW)) ia ();
  complex_accum_n_if #(.W(W), .OW(OW)) ib ();

  assign ia.in_valid  = in_valid;
  assign ia.flush     = flush;
  assign ia.out_ready = out_ready;
  assign ia.in_Re     = in_re;
  assign ia.in_Im     = in_im;
  assign ib.in_valid  = in_valid;
  assign ib.flush     = flush;
  assign ib.out_ready = out_ready;
  assign ib.in_Re     = in_re;
  assign ib.in_Im     = in_im;

  complex_accum_n #(.QI(QI), .QF(QF), .N_TERMS(N_TERMS), .SAT_EN(1)) dut_sat (
    .clk(clk), .rst(rst), .bus(ia), .state_dbg(state_s)
  );
  complex_accum_n #(.QI(QI), .QF(QF), .N_TERMS(N_TERMS), .SAT_EN(0)) dut_wrap (
    .clk(clk), .rst(rst), .bus(ib), .state_dbg(state_w)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_pass   = 0;
  logic [2*OW:0] exp_q[$];
  logic [2*OW:0] exp_w_q[$];
  int q_re[$];
  int q_im[$];
  bit model_ov = 1'b0;
  bit last_acc = 1'b0;

  task automatic check(input string name, input int got, input int exp);
    n_checks++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d at t=%0t", name, got, exp, $time);
  endtask

  function automatic bit out_of_range(input int v);
    return (v > LIM - 1) || (v < -LIM);
  endfunction

  function automatic int clamp_to(input int v);
    if (v > LIM - 1) return LIM - 1;
    if (v < -LIM) return -LIM;
    return v;
  endfunction

  function automatic int wrap_to(input int v);
    int m;
    int r;
    m = 2 * LIM;
    r = v % m;
    if (r < 0) r += m;
    if (r >= LIM) r -= m;
    return r;
  endfunction

  function automatic logic [2*OW:0] frame_result(input bit sat);
    int sr;
    int si;
    int rr;
    int ri;
    bit ov;
    sr = 0;
    si = 0;
    foreach (q_re[k]) begin
      sr += q_re[k];
      si += q_im[k];
    end
    ov = out_of_range(sr) || out_of_range(si);
    rr = sat ? clamp_to(sr) : wrap_to(sr);
    ri = sat ? clamp_to(si) : wrap_to(si);
    return {ov, rr[OW-1:0], ri[OW-1:0]};
  endfunction

  // ---------------- model + monitor (mid-cycle, inputs and outputs stable) ----------------
  always @(negedge clk) begin
    bit pred_ready;
    bit fin;
    bit hs;
    if (rst) begin
      model_ov = 1'b0;
      last_acc = 1'b0;
      q_re.delete();
      q_im.delete();
      exp_q.delete();
      exp_w_q.delete();
    end else begin
      pred_ready = !model_ov || out_ready;
      check("in_ready_sat", ia.in_ready, pred_ready);
      check("in_ready_wrap", ib.in_ready, pred_ready);
      check("out_valid_sat", ia.out_valid, model_ov);
      check("out_valid_wrap", ib.out_valid, model_ov);
      check("accum_state_sat", state_s, q_re.size() != 0);
      check("accum_state_wrap", state_w, q_re.size() != 0);
      if (ia.out_valid || ib.out_valid) begin
        if (exp_q.size() == 0 || exp_w_q.size() == 0) begin
          check("unexpected_result", 1, 0);
        end else begin
          check("result_sat", {ia.out_ovf, ia.out_Re, ia.out_Im}, exp_q[0]);
          check("result_wrap", {ib.out_ovf, ib.out_Re, ib.out_Im}, exp_w_q[0]);
          if (out_ready) begin
            void'(exp_q.pop_front());
            void'(exp_w_q.pop_front());
          end
        end
      end
      // Advance the model as the coming rising edge will.
      hs       = model_ov && out_ready;
      fin      = 1'b0;
      last_acc = in_valid && pred_ready && !flush;
      if (flush) begin
        q_re.delete();
        q_im.delete();
      end else if (last_acc) begin
        q_re.push_back(int'(in_re));
        q_im.push_back(int'(in_im));
        if (q_re.size() == N_TERMS) begin
          exp_q.push_back(frame_result(1'b1));
          exp_w_q.push_back(frame_result(1'b0));
          q_re.delete();
          q_im.delete();
          fin = 1'b1;
        end
      end
      model_ov = fin ? 1'b1 : (hs ? 1'b0 : model_ov);
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send(input int re, input int im);
    in_valid = 1'b1;
    in_re    = W'(re);
    in_im    = W'(im);
    for (int k = 0; k < 64; k++) begin
      @(posedge clk);
      if (last_acc) begin
        #1;
        in_valid = 1'b0;
        return;
      end
    end
    check("send_timeout", 0, 1);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic send_frame(input int re, input int im);
    for (int k = 0; k < N_TERMS; k++) send(re, im);
  endtask

  // Checks the result registered by the edge that just accepted the final term.
  task automatic check_out(input string tag, input int re_s, input int im_s,
                           input int re_w, input int im_w, input int ovf);
    @(negedge clk);
    #1;
    check({tag, "_valid"}, ia.out_valid, 1);
    check({tag, "_re_sat"}, ia.out_Re, re_s);
    check({tag, "_im_sat"}, ia.out_Im, im_s);
    check({tag, "_ovf_sat"}, ia.out_ovf, ovf);
    check({tag, "_re_wrap"}, ib.out_Re, re_w);
    check({tag, "_im_wrap"}, ib.out_Im, im_w);
    check({tag, "_ovf_wrap"}, ib.out_ovf, ovf);
    @(posedge clk);
    #1;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  // ---------------- main sequence ----------------
  initial begin
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    send_frame(8, -4);
    check_out("nominal", 72, -36, 72, -36, 0);

    send_frame(63, 0);
    check_out("pos_ovf", 127, 0, 55, 0, 1);

    send_frame(0, -64);
    check_out("neg_ovf", 0, -128, 0, -64, 1);

    for (int k = 0; k < N_TERMS - 1; k++) send(63, 0);
    send(-64, 0);
    check_out("cancel", 127, 0, -72, 0, 1);

    // Asynchronous reset mid-frame, with the output registers holding the last result.
    for (int k = 0; k < 4; k++) send(8, 8);
    #2;
    rst       = 1'b1;
    out_ready = 1'b0;
    #1;
    check("rst_out_valid", ia.out_valid, 0);
    check("rst_out_re", ia.out_Re, 0);
    check("rst_out_im", ia.out_Im, 0);
    check("rst_out_ovf", ia.out_ovf, 0);
    check("rst_in_ready", ia.in_ready, 1);
    check("rst_out_re_wrap", ib.out_Re, 0);
    check("rst_out_ovf_wrap", ib.out_ovf, 0);
    check("rst_in_ready_wrap", ib.in_ready, 1);
    @(posedge clk);
    #1;
    rst       = 1'b0;
    out_ready = 1'b1;
    send_frame(8, 0);
    check_out("after_rst", 72, 0, 72, 0, 0);

    // Backpressure: result held while frame 2 stalls, then frame 2 resumes.
    out_ready = 1'b0;
    send_frame(8, -8);
    in_valid = 1'b1;
    in_re    = W'(1);
    in_im    = W'(-1);
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      #1;
      check("stall_in_ready", ia.in_ready, 0);
      check("stall_out_valid", ia.out_valid, 1);
      check("stall_out_re", ia.out_Re, 72);
      check("stall_out_im", ia.out_Im, -72);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    for (int k = 1; k <= N_TERMS; k++) send(k, -k);
    check_out("backpressure", 45, -45, 45, -45, 0);

    // Flush together with a presented sample discards both the partial frame and it.
    for (int k = 0; k < 4; k++) send(16, 0);
    in_valid = 1'b1;
    flush    = 1'b1;
    in_re    = W'(40);
    in_im    = W'(0);
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    send_frame(8, 0);
    check_out("flush", 72, 0, 72, 0, 0);

    // Randomized traffic with gaps, backpressure, flushes and extreme values.
    for (int c = 0; c < 2000; c++) begin
      in_valid  = ($urandom_range(0, 3) != 0);
      out_ready = ($urandom_range(0, 3) != 0);
      flush     = ($urandom_range(0, 40) == 0);
      if ($urandom_range(0, 2) == 0) begin
        in_re = ($urandom_range(0, 1) != 0) ? MAXI : MINI;
        in_im = ($urandom_range(0, 1) != 0) ? MAXI : MINI;
      end else begin
        in_re = W'($urandom_range(0, (1 << W) - 1));
        in_im = W'($urandom_range(0, (1 << W) - 1));
      end
      @(posedge clk);
      #1;
    end

    in_valid  = 1'b0;
    flush     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    flush = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("drain_sat", exp_q.size(), 0);
    check("drain_wrap", exp_w_q.size(), 0);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end
endmodule
